// File: rtl/sm_adder_table_writer_if.sv
// Write-port bundle between the sign-magnitude table writer and the table RAM,
// plus the start/busy/done handshake toward bring-up control.
interface sm_adder_table_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) ();
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH:0]   wr_data;

  modport master (
    input  start, wr_ready,
    output busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, wr_ready,
    input  busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sm_adder_table_writer.sv
// Walks every {a, b} address once and writes the sign-magnitude sum a+b to the
// lookup-table RAM, one beat per accepted cycle.
module sm_adder_table_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  sm_adder_table_writer_if.master bus
);

  if (ADDR_WIDTH != 2 * DATA_WIDTH) begin : g_bad_width
    $error("sm_adder_table_writer: ADDR_WIDTH must equal 2*DATA_WIDTH");
  end

  localparam int MAG_W = DATA_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic                  xfer;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH:0]   data_d;
  logic                  wr_en_d;
  logic                  busy_d;
  logic                  done_d;

  // Table entry for one address; a zero magnitude never carries a minus sign.
  function automatic logic [DATA_WIDTH:0] sm_sum(input logic [ADDR_WIDTH-1:0] addr);
    logic             sa;
    logic             sb;
    logic [MAG_W-1:0] ma;
    logic [MAG_W-1:0] mb;
    logic [DATA_WIDTH-1:0] mag;
    logic             sign;
    sa = addr[ADDR_WIDTH-1];
    ma = addr[ADDR_WIDTH-2 -: MAG_W];
    sb = addr[DATA_WIDTH-1];
    mb = addr[MAG_W-1:0];
    if (sa == sb) begin
      mag  = {1'b0, ma} + {1'b0, mb};
      sign = sa;
    end else if (ma > mb) begin
      mag  = {1'b0, ma - mb};
      sign = sa;
    end else begin
      mag  = {1'b0, mb - ma};
      sign = sb;
    end
    if (mag == '0) sign = 1'b0;
    return {sign, mag};
  endfunction

  // The registered wr_addr doubles as the build counter.
  assign xfer      = (state == WRITE) && bus.wr_ready;
  assign last_beat = (bus.wr_addr == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus.wr_en   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      state       <= next_state;
      bus.wr_en   <= wr_en_d;
      bus.busy    <= busy_d;
      bus.done    <= done_d;
      bus.wr_addr <= addr_d;
      bus.wr_data <= data_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = WRITE;
      WRITE:   if (xfer && last_beat) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    addr_d = bus.wr_addr;
    if (state == IDLE && bus.start) begin
      addr_d = '0;
    end else if (xfer && !last_beat) begin
      addr_d = bus.wr_addr + ADDR_ONE;
    end
    data_d  = sm_sum(addr_d);
    wr_en_d = (next_state == WRITE);
    busy_d  = (next_state == WRITE);
    done_d  = (next_state == DONE);
  end

endmodule

// File: tb/tb_sm_adder_table_writer.sv
// Scoreboard bench: full-size build with a mid-build reset and restart, plus a
// DATA_WIDTH=4 build under random backpressure.
module tb_sm_adder_table_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sm_adder_table_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) big_if ();
  sm_adder_table_writer_if #(.DATA_WIDTH(4), .ADDR_WIDTH(8))  small_if ();

  sm_adder_table_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) u_big (
    .clk(clk), .reset(reset), .bus(big_if.master));
  sm_adder_table_writer #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) u_small (
    .clk(clk), .reset(reset), .bus(small_if.master));

  typedef struct {int addr; int data;} beat_t;
  beat_t big_q[$];
  beat_t small_q[$];

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int big_beats = 0, big_dones = 0, big_done_cyc = 0, big_spot_hits = 0;
  int small_beats = 0, small_dones = 0, small_spot_hits = 0;
  bit bp_en = 1'b0;

  int big_spot_addr [8] = '{'h0102, 'h0284, 'h8401, 'h8282, 'hB979, 'h7F7F, 'h8000, 'h0585};
  int big_spot_data [8] = '{'h003,  'h102,  'h103,  'h104,  'h040,  'h0FE,  'h000,  'h000};
  int small_spot_addr [2] = '{'h9A, 'h3B};
  int small_spot_data [2] = '{'h13, 'h00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed integer add, then re-encode as sign-magnitude.
  function automatic int model(int dw, int addr);
    int a, b, mmask, va, vb, s;
    a     = addr >> dw;
    b     = addr & ((1 << dw) - 1);
    mmask = (1 << (dw - 1)) - 1;
    va    = ((a >> (dw - 1)) & 1) ? -(a & mmask) : (a & mmask);
    vb    = ((b >> (dw - 1)) & 1) ? -(b & mmask) : (b & mmask);
    s     = va + vb;
    return (s < 0) ? ((1 << dw) | -s) : s;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (big_if.wr_en && big_if.wr_ready) begin
      big_beats++;
      if (big_q.size() == 0) check("big_unexpected_beat", 32'(big_if.wr_addr), 32'hFFFF_FFFF);
      else begin
        e = big_q.pop_front();
        check("big_addr", 32'(big_if.wr_addr), e.addr);
        check("big_data", 32'(big_if.wr_data), e.data);
      end
      for (int k = 0; k < 8; k++)
        if (32'(big_if.wr_addr) == big_spot_addr[k]) begin
          big_spot_hits++;
          check("big_spot", 32'(big_if.wr_data), big_spot_data[k]);
        end
    end
    if (big_if.done) begin
      big_dones++;
      big_done_cyc = cyc;
      check("big_done_before_last", big_q.size(), 0);
    end
  end

  logic       s_prev_stall = 1'b0;
  logic [7:0] s_prev_addr = '0;
  logic [4:0] s_prev_data = '0;

  always @(negedge clk) begin
    beat_t e;
    if (s_prev_stall) begin
      check("small_hold_en",   32'(small_if.wr_en),   1);
      check("small_hold_addr", 32'(small_if.wr_addr), 32'(s_prev_addr));
      check("small_hold_data", 32'(small_if.wr_data), 32'(s_prev_data));
    end
    s_prev_stall = small_if.wr_en && !small_if.wr_ready;
    s_prev_addr  = small_if.wr_addr;
    s_prev_data  = small_if.wr_data;
    if (small_if.wr_en && small_if.wr_ready) begin
      small_beats++;
      if (small_q.size() == 0) check("small_unexpected_beat", 32'(small_if.wr_addr), 32'hFFFF_FFFF);
      else begin
        e = small_q.pop_front();
        check("small_addr", 32'(small_if.wr_addr), e.addr);
        check("small_data", 32'(small_if.wr_data), e.data);
      end
      for (int k = 0; k < 2; k++)
        if (32'(small_if.wr_addr) == small_spot_addr[k]) begin
          small_spot_hits++;
          check("small_spot", 32'(small_if.wr_data), small_spot_data[k]);
        end
    end
    if (small_if.done) begin
      small_dones++;
      check("small_done_before_last", small_q.size(), 0);
    end
  end

  initial begin
    small_if.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 small_if.wr_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_big();
    beat_t e;
    big_q.delete();
    for (int i = 0; i < 65536; i++) begin
      e.addr = i;
      e.data = model(8, i);
      big_q.push_back(e);
    end
  endtask

  task automatic start_big(output int start_cyc);
    @(posedge clk);
    #1 big_if.start = 1'b1;
    @(posedge clk);
    #1 big_if.start = 1'b0;
    start_cyc = cyc;
    check("big_start_wr_en", 32'(big_if.wr_en), 1);
    check("big_start_busy",  32'(big_if.busy),  1);
    check("big_start_addr",  32'(big_if.wr_addr), 0);
  endtask

  initial begin
    int  start_cyc;
    bit  hit;
    beat_t e;
    big_if.start = 1'b0;
    big_if.wr_ready = 1'b1;
    small_if.start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",   32'(big_if.wr_en),   0);
    check("rst_busy",    32'(big_if.busy),    0);
    check("rst_done",    32'(big_if.done),    0);
    check("rst_wr_addr", 32'(big_if.wr_addr), 0);
    check("rst_wr_data", 32'(big_if.wr_data), 0);
    check("rst_small_wr_en", 32'(small_if.wr_en), 0);
    @(negedge clk) reset = 1'b0;

    // Build aborted by reset at 0x1234.
    push_big();
    start_big(start_cyc);
    hit = 1'b0;
    for (int i = 0; i < 10000 && !hit; i++) begin
      @(negedge clk);
      if (big_if.wr_addr == 16'h1234) hit = 1'b1;
    end
    check("big_reach_1234", 32'(hit), 1);
    #2 reset = 1'b1;
    #1;
    check("async_wr_en",   32'(big_if.wr_en),   0);
    check("async_busy",    32'(big_if.busy),    0);
    check("async_done",    32'(big_if.done),    0);
    check("async_wr_addr", 32'(big_if.wr_addr), 0);
    check("async_wr_data", 32'(big_if.wr_data), 0);
    big_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("no_done_after_abort", big_dones, 0);

    // Full build from address 0, with stray start pulses while writing.
    push_big();
    big_beats = 0;
    big_spot_hits = 0;
    start_big(start_cyc);
    hit = 1'b0;
    for (int i = 0; i < 70000 && !hit; i++) begin
      @(negedge clk);
      if (big_if.done) hit = 1'b1;
      else big_if.start = (i == 100 || i == 5000 || i == 40000);
    end
    check("big_done_seen", 32'(hit), 1);
    // start during the done cycle must be ignored
    big_if.start = 1'b1;
    @(posedge clk);
    #1 big_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check("big_idle_wr_en", 32'(big_if.wr_en), 0);
    check("big_idle_busy",  32'(big_if.busy),  0);
    check("big_idle_done",  32'(big_if.done),  0);
    check("big_beats",      big_beats, 65536);
    check("big_dones",      big_dones, 1);
    check("big_q_empty",    big_q.size(), 0);
    // done is seen after edge N+65536: the 65537th cycle counting acceptance
    check("big_done_latency", big_done_cyc - start_cyc, 65536);
    check("big_spot_hits",  big_spot_hits, 8);

    // Small instance under random backpressure.
    small_q.delete();
    for (int i = 0; i < 256; i++) begin
      e.addr = i;
      e.data = model(4, i);
      small_q.push_back(e);
    end
    bp_en = 1'b1;
    @(posedge clk);
    #2 small_if.start = 1'b1;
    @(posedge clk);
    #2 small_if.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      if (small_if.done) hit = 1'b1;
    end
    check("small_done_seen", 32'(hit), 1);
    bp_en = 1'b0;
    repeat (3) @(negedge clk);
    check("small_beats",     small_beats, 256);
    check("small_dones",     small_dones, 1);
    check("small_q_empty",   small_q.size(), 0);
    check("small_spot_hits", small_spot_hits, 2);
    check("small_idle_busy", 32'(small_if.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
